// File: rtl/button_event_decoder_pkg.sv
// Shared types and default timing for the button event decoder.
// State encoding, default hold/repeat periods and a small parameter helper.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESSED   = 2'b01,
    LONG_HELD = 2'b10
  } state_t;

  localparam int LONG_CYCLES_DEF   = 100000000;
  localparam int REPEAT_CYCLES_DEF = 20000000;
  localparam int CNT_W_DEF         = 27;

  function automatic longint max_cycles(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, event pulses out; master drives the button, slave is the decoder.
interface button_event_decoder_if;

  logic btn_i;
  logic press_o;
  logic release_o;
  logic short_o;
  logic long_o;
  logic repeat_o;
  logic held_o;

  modport master (
    output btn_i,
    input  press_o, release_o, short_o, long_o, repeat_o, held_o
  );

  modport slave (
    input  btn_i,
    output press_o, release_o, short_o, long_o, repeat_o, held_o
  );

endinterface

// File: rtl/button_event_decoder_hold_timer.sv
// Hold counter with clear, enable and a selectable terminal value (long or repeat period).
// tc strobes on the last count of the selected period; the counter wraps to 0 there.
module btn_hold_timer #(
  parameter int CNT_W         = 27,
  parameter int LONG_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 20000000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  input  logic sel_long,
  output logic tc
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last;

  assign last = sel_long ? LONG_LAST : REPEAT_LAST;
  assign tc   = en && (count == last);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long/repeat pulses.
// Auto-repeat is built only when BTN_EVT_REPEAT_EN is defined; otherwise repeat_o is 0.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   n_rst,
  button_event_decoder_if.slave  bus
);

  localparam longint MAX_CYC = max_cycles(longint'(LONG_CYCLES), longint'(REPEAT_CYCLES));

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 || CNT_W < 1 ||
      (CNT_W < 63 && (longint'(1) << CNT_W) <= MAX_CYC)) begin : g_bad_params
    $error("button_event_decoder: invalid CNT_W/LONG_CYCLES/REPEAT_CYCLES");
  end

  state_t state;
  logic   btn_q;
  logic   rise, fall;
  logic   press_q, rel_q, short_q, long_q, held_q;
  logic   tmr_clr, tmr_en, tmr_sel, tmr_tc;

  assign rise = bus.btn_i & ~btn_q;
  assign fall = ~bus.btn_i & btn_q;

  // The counter idles at 0 and restarts whenever the hold ends.
  assign tmr_clr = (state == IDLE) | fall;
`ifdef BTN_EVT_REPEAT_EN
  assign tmr_en  = (state == PRESSED) | (state == LONG_HELD);
  assign tmr_sel = (state == PRESSED);
`else
  assign tmr_en  = (state == PRESSED);
  assign tmr_sel = 1'b1;
`endif

  btn_hold_timer #(
    .CNT_W         (CNT_W),
    .LONG_CYCLES   (LONG_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .sel_long (tmr_sel),
    .tc       (tmr_tc)
  );

`ifdef BTN_EVT_REPEAT_EN
  logic rpt_q;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rpt_q   <= 1'b0;
`endif
    end else begin
      btn_q   <= bus.btn_i;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rpt_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= PRESSED;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end
        end
        PRESSED: begin
          // A release on the threshold cycle wins over long.
          if (fall) begin
            state   <= IDLE;
            rel_q   <= 1'b1;
            short_q <= 1'b1;
            held_q  <= 1'b0;
          end else if (tmr_tc) begin
            state   <= LONG_HELD;
            long_q  <= 1'b1;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state  <= IDLE;
            rel_q  <= 1'b1;
            held_q <= 1'b0;
          end
`ifdef BTN_EVT_REPEAT_EN
          else if (tmr_tc) begin
            rpt_q <= 1'b1;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_o   = press_q;
  assign bus.release_o = rel_q;
  assign bus.short_o   = short_q;
  assign bus.long_o    = long_q;
  assign bus.held_o    = held_q;
`ifdef BTN_EVT_REPEAT_EN
  assign bus.repeat_o  = rpt_q;
`else
  assign bus.repeat_o  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4; adapts to BTN_EVT_REPEAT_EN.
// Outputs are compared each cycle against a hold-length model: {press,release,short,long,repeat,held}.
module tb_button_event_decoder;

  localparam int LONG   = 8;
  localparam int REPEAT = 4;
`ifdef BTN_EVT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  button_event_decoder_if bus();

  button_event_decoder #(
    .CNT_W         (4),
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REPEAT)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: tracks whether a hold is active and how many edges have passed since its press.
  logic m_btn_prev = 1'b0;
  bit   m_active   = 1'b0;
  int   m_h        = 0;

  function automatic logic [5:0] observed();
    return {bus.press_o, bus.release_o, bus.short_o, bus.long_o, bus.repeat_o, bus.held_o};
  endfunction

  task automatic model_reset();
    m_btn_prev = 1'b0;
    m_active   = 1'b0;
    m_h        = 0;
  endtask

  task automatic model_edge(input logic b, output logic [5:0] e);
    logic p, r, s, l, rp;
    {p, r, s, l, rp} = '0;
    if (!m_active) begin
      if (b && !m_btn_prev) begin
        m_active = 1'b1;
        m_h      = 0;
        p        = 1'b1;
      end
    end else if (!b) begin
      m_h++;
      r        = 1'b1;
      s        = (m_h <= LONG);
      m_active = 1'b0;
    end else begin
      m_h++;
      l  = (m_h == LONG);
      rp = REP_EN && (m_h > LONG) && ((m_h - LONG) % REPEAT == 0);
    end
    m_btn_prev = b;
    e = {p, r, s, l, rp, m_active};
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input logic b, output logic [5:0] e, output logic [5:0] o);
    @(negedge clk);
    bus.btn_i = b;
    @(posedge clk);
    #1;
    model_edge(b, e);
    o = observed();
  endtask

  task automatic test_reset();
    logic [5:0] o;
    bus.btn_i = 1'b0;
    n_rst     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      o = observed();
      checks++;
      if (o !== 6'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b expected %b", i, o, 6'b0);
      end
    end
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_short_press();
    logic [5:0] e, o;
    for (int i = 0; i < 10; i++) begin
      cycle(i < 5, e, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL short_press cyc%0d: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [5:0] e, o;
    int longs = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(i < 20, e, o);
      longs += o[2];
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL long_hold cyc%0d: got %b expected %b", i, o, e);
      end
    end
    checks++;
    if (longs !== 1) begin
      errors++;
      $display("FAIL long_hold_count: got %0d long pulses expected 1", longs);
    end
  endtask

  task automatic test_threshold_collision();
    logic [5:0] e, o;
    int longs = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(i < LONG, e, o);
      longs += o[2];
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL collision cyc%0d: got %b expected %b", i, o, e);
      end
    end
    checks++;
    if (longs !== 0) begin
      errors++;
      $display("FAIL collision_long: got %0d long pulses expected 0", longs);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e, o;
    logic [9:0] pat;
    int shorts = 0;
    pat = 10'b0001110111;
    for (int i = 0; i < 10; i++) begin
      cycle(pat[i], e, o);
      shorts += o[3];
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", i, o, e);
      end
    end
    checks++;
    if (shorts !== 2) begin
      errors++;
      $display("FAIL back_to_back_shorts: got %0d expected 2", shorts);
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] e, o;
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, e, o);
    end
    #2;
    n_rst = 1'b0;
    #1;
    o = observed();
    checks++;
    if (o !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_clear: got %b expected %b", o, 6'b0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle(i < 12, e, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_reset_resume cyc%0d: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] e, o;
    int hi, lo;
    for (int burst = 0; burst < 40; burst++) begin
      hi = $urandom_range(1, 24);
      lo = $urandom_range(1, 3);
      for (int i = 0; i < hi + lo; i++) begin
        cycle(i < hi, e, o);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL random b%0d cyc%0d: got %b expected %b", burst, i, o, e);
        end
      end
    end
  endtask

  initial begin
    bus.btn_i = 1'b0;
    test_reset();
    test_short_press();
    test_long_hold();
    test_threshold_collision();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
